// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : alu_pkg                                                    |
// | Purpose  : Opcode encoding and FSM state encoding shared by the       |
// |            serial ALU and the decode stage.                           |
// | Contents : OP_* opcode localparams, opcode_t, state_t (IDLE, RUN)     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_PASS_A = 3'b000;
  localparam opcode_t OP_PASS_B = 3'b001;
  localparam opcode_t OP_NOT_A  = 3'b010;
  localparam opcode_t OP_NOT_B  = 3'b011;
  localparam opcode_t OP_AND    = 3'b100;
  localparam opcode_t OP_OR     = 3'b101;
  localparam opcode_t OP_XOR    = 3'b110;
  localparam opcode_t OP_ADD    = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_digit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : alu_digit                                                  |
// | Purpose  : Combinational DIGIT-bit ALU slice.                         |
// | Ports    : a, b  (in,  DIGIT) operand digits                          |
// |            op    (in,  3)     opcode                                  |
// |            cin   (in,  1)     carry in (add only)                     |
// |            c     (out, DIGIT) result digit                            |
// |            cout  (out, 1)     carry out, 0 for non-add ops            |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  opcode_t          op,
  input  logic             cin,
  output logic [DIGIT-1:0] c,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

  always_comb begin
    c    = '0;
    cout = 1'b0;
    case (op)
      OP_PASS_A: c = a;
      OP_PASS_B: c = b;
      OP_NOT_A:  c = ~a;
      OP_NOT_B:  c = ~b;
      OP_AND:    c = a & b;
      OP_OR:     c = a | b;
      OP_XOR:    c = a ^ b;
      OP_ADD: begin
        c    = sum[DIGIT-1:0];
        cout = sum[DIGIT];
      end
      default: c = '0;
    endcase
  end

endmodule : alu_digit
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : serial_alu                                                 |
// | Purpose  : Multi-cycle ALU, DIGIT bits per clock, start/busy/done.    |
// | Ports    : clk, rst (async, active high)                              |
// |            start, op[2:0], a, b [WIDTH], cin  -- request              |
// |            busy, done (1-cycle pulse)                                 |
// |            c [WIDTH], cout, zero, ovf -- registered, held until the   |
// |            next completion                                            |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  opcode_t          op_r;
  logic             carry_r, a_msb, b_msb, zacc;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] dig_c;
  logic             dig_cout;
  logic             last_edge;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .op   (op_r),
    .cin  (carry_r),
    .c    (dig_c),
    .cout (dig_cout)
  );

  // New digit enters at the top; after N shifts the first digit sits at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = dig_c;
    end else begin : g_shift
      assign res_next = {dig_c, res_sr[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last_edge = (state == RUN) && (count == LAST);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      op_r    <= OP_PASS_A;
      carry_r <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      zacc    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      c       <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr    <= a;
          b_sr    <= b;
          op_r    <= op;
          carry_r <= cin;
          a_msb   <= a[WIDTH-1];
          b_msb   <= b[WIDTH-1];
          res_sr  <= '0;
          zacc    <= 1'b0;
          count   <= '0;
        end
      end else begin
        a_sr    <= a_sr >> DIGIT;
        b_sr    <= b_sr >> DIGIT;
        res_sr  <= res_next;
        carry_r <= dig_cout;  // slice forces 0 for non-add ops
        zacc    <= zacc | (|dig_c);
        count   <= count + 1'b1;
        if (last_edge) begin
          c    <= res_next;
          cout <= dig_cout;
          zero <= ~(zacc | (|dig_c));
          ovf  <= (op_r == OP_ADD) && (a_msb == b_msb) &&
                  (res_next[WIDTH-1] != a_msb);
          done <= 1'b1;
        end
      end
    end
  end

endmodule : serial_alu
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_serial_alu                                              |
// | Purpose  : Directed self-checking bench for serial_alu (8-bit, 2/clk) |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout, zero, ovf;
  logic [7:0] c;

  int checks = 0;
  int errors = 0;

  serial_alu #(.WIDTH(8), .DIGIT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .cout  (cout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Enter and leave at a negedge. Returns edges from acceptance to the
  // negedge where done is first seen (20 = timed out).
  task automatic do_op(input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci, output int lat);
    op = o; a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    if (!done) begin
      while (lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (done) break;
      end
    end
    if (lat == 0) lat = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, c, cout, zero, ovf} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b c=%h cout=%b zero=%b ovf=%b, want all 0",
               busy, done, c, cout, zero, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    do_op(3'b111, 8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if ({c, cout, ovf, zero} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_7f_01: got c=%h cout=%b ovf=%b zero=%b want c=80 cout=0 ovf=1 zero=0", c, cout, ovf, zero);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done_cycle: got %b want 0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || c !== 8'h80) begin
      errors++; $display("FAIL done_one_cycle: got done=%b c=%h want done=0 c=80", done, c);
    end

    do_op(3'b111, 8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if ({c, cout, zero, ovf} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_01: got c=%h cout=%b zero=%b ovf=%b want c=00 cout=1 zero=1 ovf=0", c, cout, zero, ovf);
    end
    do_op(3'b111, 8'hFF, 8'h01, 1'b1, lat);
    checks++;
    if ({c, cout, zero, ovf} !== {8'h01, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_01_cin: got c=%h cout=%b zero=%b ovf=%b want c=01 cout=1 zero=0 ovf=0", c, cout, zero, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_logic_sweep();
    logic [7:0] exp_c [7] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h24, 8'hBD, 8'h99};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(3'(i), 8'hA5, 8'h3C, 1'b1, lat);
      checks++;
      if (lat !== 4 || {c, cout, ovf, zero} !== {exp_c[i], 3'b000}) begin
        errors++;
        $display("FAIL logic_op%0d: got lat=%0d c=%h cout=%b ovf=%b zero=%b want lat=4 c=%h cout=0 ovf=0 zero=0",
                 i, lat, c, cout, ovf, zero, exp_c[i]);
      end
      @(negedge clk);
    end
    do_op(3'b110, 8'hA5, 8'hA5, 1'b0, lat);
    checks++;
    if ({c, zero, cout, ovf} !== {8'h00, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL xor_zero: got c=%h zero=%b cout=%b ovf=%b want c=00 zero=1 cout=0 ovf=0", c, zero, cout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    op = 3'b111; a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Same start held high with new operands while busy.
    op = 3'b000; a = 8'h00; b = 8'hFF; cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        pulses++;
        checks++;
        if ({c, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
          errors++; $display("FAIL ignore_start_result: got c=%h cout=%b ovf=%b want c=80 cout=0 ovf=1", c, cout, ovf);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ignore_start_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int edges = 0;
    int held_bad = 0;
    do_op(3'b111, 8'h7F, 8'h01, 1'b0, lat);  // c=80 now
    // Start in the done cycle.
    op = 3'b000; a = 8'h11; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (edges < 20) begin
      if (!busy && edges == 0) break;  // not accepted
      if (done) break;
      if (c !== 8'h80) held_bad++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges !== 4 || c !== 8'h11 || done !== 1'b1) begin
      errors++; $display("FAIL back_to_back: got edges=%0d c=%h done=%b want edges=4 c=11 done=1", edges, c, done);
    end
    checks++;
    if (held_bad !== 0) begin errors++; $display("FAIL back_to_back_hold: got %0d cycles with c!=80 want 0", held_bad); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int lat;
    int pulses = 0;
    op = 3'b111; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);  // count = 2
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, c, cout, zero, ovf} !== 13'd0) begin
      errors++;
      $display("FAIL reset_midop: got busy=%b done=%b c=%h cout=%b zero=%b ovf=%b want all 0",
               busy, done, c, cout, zero, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", pulses); end
    do_op(3'b111, 8'h12, 8'h34, 1'b1, lat);
    checks++;
    if (lat !== 4 || {c, cout, zero, ovf} !== {8'h47, 3'b000}) begin
      errors++;
      $display("FAIL after_reset_op: got lat=%0d c=%h cout=%b zero=%b ovf=%b want lat=4 c=47 0 0 0",
               lat, c, cout, zero, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_alu
`default_nettype wire

// File: doc/serial_alu.md
# serial_alu

Multi-cycle, parametrised successor to the single-bit ALU slice. Computes one of eight operations on WIDTH-bit operands, DIGIT bits per clock, through a start/busy/done handshake. Result and flags (carry-out, zero, signed overflow) are registered and held until the next accepted operation. It sits between the register file and the writeback stage of the datapath where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; multiple of DIGIT
- DIGIT, 2, bits processed per clock; N = WIDTH/DIGIT cycles per operation
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  3  opcode: 000 pass a, 001 pass b, 010 ~a, 011 ~b, 100 a&b, 101 a|b, 110 a^b, 111 a+b+cin
- a, b  input  WIDTH  operands, sampled on acceptance only
- cin  input  1  carry-in, used by op 111 only
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result/flags valid
- c  output  WIDTH  result
- cout  output  1  carry out of MSB (op 111), else 0
- zero  output  1  c == 0
- ovf  output  1  signed overflow (op 111), else 0

## Operation
- Reset: all outputs 0, state IDLE, internal operand/carry/count registers 0. Applies immediately (asynchronous); an operation in flight is abandoned with no done pulse.
- States: IDLE, RUN.
  - IDLE: on start=1, latch a, b, op, cin, and MSBs of a and b. Clear the result register and the zero accumulator. Set count=0, busy=1, and go to RUN. start=0 holds state.
  - RUN: each edge, the digit slice processes the low DIGIT bits of the operand shift registers with the carry register. The result digit enters the top of the result shift register, which shifts right by DIGIT. The operands shift right by DIGIT. Carry register takes the slice carry for op 111 and stays 0 otherwise. Zero accumulator ORs in the digit. count increments.
  - When count = N-1 on that edge, update c and cout, update zero from the final accumulator, and compute ovf = (a_msb == b_msb) && (c[WIDTH-1] != a_msb) for op 111, else 0. Set busy=0, set done=1, and return to IDLE.
- done is high for exactly one cycle. c, cout, zero and ovf hold their values until the next acceptance. On acceptance they are not cleared; they update only at completion.
- start while busy=1 is ignored (not queued). Operand changes while busy have no effect.
- Arithmetic: unsigned modulo 2^WIDTH addition. cout is bit WIDTH of a+b+cin. No subtract op; callers use ~b with cin=1 over two operations.

## Timing
- Acceptance edge E0 (start=1, busy=0). busy is high from after E0 until after E0+N. done is high during the cycle after edge E0+N. Latency is N edges from acceptance to result.
- DIGIT=WIDTH gives N=1: done is asserted one edge after acceptance.
- busy is low in the done cycle. A start in that cycle is accepted, giving back-to-back operations at one per N+1 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg: opcode localparams (OP_PASS_A … OP_ADD) and the state encoding (IDLE, RUN); reused by the decode stage.
- One sub-module, alu_digit: purely combinational DIGIT-bit slice (inputs a, b, op, cin; outputs c, cout). Generalises the existing single-bit slice. cout is forced to 0 for non-add ops.
- Counter width: $clog2(N) with a minimum of 1.

## Test plan
(WIDTH=8, DIGIT=2, N=4.)
- Op 111, a=7F, b=01, cin=0 -> done exactly 4 edges after acceptance; c=80, cout=0, ovf=1, zero=0.
- Op 111, a=FF, b=01, cin=0 -> c=00, cout=1, zero=1, ovf=0; same with cin=1 -> c=01, zero=0.
- Sweep ops 000–110 with a=A5, b=3C -> c = A5, 3C, 5A, C3, 24, BD, 99; cout=0 and ovf=0 throughout. Op 110 with a=b=A5 -> zero=1.
- Assert start=1 with new operands during RUN -> ignored; the first result completes unchanged and only one done pulse occurs.
- Raise start in the done cycle with op 000, a=11 -> accepted; next done 4 edges later with c=11; the previous c holds until then.
- Assert rst at count=2 -> busy, done, c and flags go to 0 immediately with no done pulse; a new start after release completes normally.
